// File: rtl/mem_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package : mpp_seq_pkg
// Purpose : Shared definitions for the memory sequencer: FSM state encoding,
//           wait-counter width, pc_signals bit positions and the fixed
//           program-addresser control words.
// Rev     : 1.0  initial release
// ============================================================================
package mpp_seq_pkg;

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned PC_SIG_W = 5;

  // Bit positions inside the 5-bit program-addresser control word.
  localparam int unsigned SEL_DATA_PC = 0;
  localparam int unsigned PCH_CAR     = 1;
  localparam int unsigned PCL_CAR     = 2;
  localparam int unsigned PCH_BUS     = 3;
  localparam int unsigned PCL_BUS     = 4;

  // PC increment: load both halves from the incrementer path.
  localparam logic [PC_SIG_W-1:0] PC_CW_INC =
      PC_SIG_W'(1 << PCH_CAR) | PC_SIG_W'(1 << PCL_CAR);
  // Jump load of the low byte from pc_bus.
  localparam logic [PC_SIG_W-1:0] PC_CW_LD_LOW =
      PC_SIG_W'(1 << SEL_DATA_PC) | PC_SIG_W'(1 << PCL_CAR);
  // Jump load of the high byte from pc_bus.
  localparam logic [PC_SIG_W-1:0] PC_CW_LD_HIGH =
      PC_SIG_W'(1 << SEL_DATA_PC) | PC_SIG_W'(1 << PCH_CAR);
  // PC drives the ROM address bus during instruction reads.
  localparam logic [PC_SIG_W-1:0] PC_CW_ROM_RD =
      PC_SIG_W'(1 << PCL_BUS) | PC_SIG_W'(1 << PCH_BUS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ROM_RD   = 3'd1,
    S_ROM_DONE = 3'd2,
    S_LD_LOW   = 3'd3,
    S_LD_HIGH  = 3'd4,
    S_RAM_RD   = 3'd5,
    S_RAM_DONE = 3'd6
  } state_t;

endpackage : mpp_seq_pkg
`default_nettype wire

// File: rtl/mem_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_sequencer_if
// Purpose   : Bundles the control-module requests, the external memory bus
//             and the program-addresser control outputs of mem_sequencer.
// Modports  : master - requester/environment side (drives requests, jump
//                      address and the shared memory data bus)
//             slave  - the sequencer itself
// Rev       : 1.0  initial release
// ============================================================================
interface mem_sequencer_if;
  import mpp_seq_pkg::*;

  logic                fetch_req;
  logic                jump_req;
  logic                ram_req;
  logic [15:0]         jump_addr;
  logic [7:0]          data_in;
  logic [PC_SIG_W-1:0] pc_signals;
  logic [7:0]          pc_bus;
  logic                rom_cs;
  logic                rom_rd;
  logic                ram_cs;
  logic                ram_rd;
  logic [7:0]          instr;
  logic                instr_valid;
  logic                jump_done;
  logic                ram_valid;
  logic [7:0]          ram_data;
  logic                busy;

  modport master (
    output fetch_req, jump_req, ram_req, jump_addr, data_in,
    input  pc_signals, pc_bus, rom_cs, rom_rd, ram_cs, ram_rd,
    input  instr, instr_valid, jump_done, ram_valid, ram_data, busy
  );

  modport slave (
    input  fetch_req, jump_req, ram_req, jump_addr, data_in,
    output pc_signals, pc_bus, rom_cs, rom_rd, ram_cs, ram_rd,
    output instr, instr_valid, jump_done, ram_valid, ram_data, busy
  );

endinterface : mem_sequencer_if
`default_nettype wire

// File: rtl/mem_sequencer_wait_counter.sv
`default_nettype none
// ============================================================================
// Module  : seq_wait_counter
// Purpose : 4-bit loadable down-counter with zero flag, shared by the ROM
//           and RAM wait sequences. Saturates at zero.
// Ports   : clk, rst_n     - clock, asynchronous active-low reset
//           i_load         - load i_load_val (has priority over i_dec)
//           i_load_val     - value to load
//           i_dec          - decrement by one while nonzero
//           o_zero         - counter equals zero
// Rev     : 1.0  initial release
// ============================================================================
module seq_wait_counter
  import mpp_seq_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_load,
  input  wire logic [CNT_W-1:0] i_load_val,
  input  wire logic             i_dec,
  output logic                  o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule : seq_wait_counter
`default_nettype wire

// File: rtl/mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : mem_sequencer
// Purpose : Memory-side sequencer of the 8-bit processor. Fetches
//           instructions from ROM, reads operands from RAM and loads 16-bit
//           jump targets into the program addresser, arbitrating concurrent
//           requests (jump > RAM > fetch). All outputs are registered.
// Params  : ROM_WAIT, RAM_WAIT - strobe cycles before sampling (1..15)
// Ports   : clk    - system clock, rising edge
//           rst_n  - asynchronous active-low reset
//           bus    - mem_sequencer_if.slave (requests, memory bus,
//                    program-addresser controls, results, busy)
// Macro   : MPP_SEQ_RAM_EN - when defined, the RAM read path is built;
//           otherwise ram_req is ignored and all ram_* outputs are 0.
// Rev     : 1.0  initial release
// ============================================================================
module mem_sequencer
  import mpp_seq_pkg::*;
#(
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned RAM_WAIT = 1
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  mem_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] c_rom_load = CNT_W'(ROM_WAIT - 1);

  state_t              r_state;
  logic [PC_SIG_W-1:0] r_pc_signals;
  logic [7:0]          r_pc_bus;
  logic                r_rom_cs;
  logic                r_rom_rd;
  logic [7:0]          r_instr;
  logic                r_instr_valid;
  logic                r_jump_done;
  logic                r_busy;

  logic                w_idle;
  logic                w_take_jump;
  logic                w_take_ram;
  logic                w_take_rom;
  logic                w_cnt_load;
  logic [CNT_W-1:0]    w_cnt_load_val;
  logic                w_cnt_dec;
  logic                w_cnt_zero;

  // Arbitration: decided only while idle, highest priority first.
  assign w_idle      = (r_state == S_IDLE);
  assign w_take_jump = w_idle && bus.jump_req;
`ifdef MPP_SEQ_RAM_EN
  localparam logic [CNT_W-1:0] c_ram_load = CNT_W'(RAM_WAIT - 1);

  logic       r_ram_cs;
  logic       r_ram_rd;
  logic       r_ram_valid;
  logic [7:0] r_ram_data;

  assign w_take_ram     = w_idle && !bus.jump_req && bus.ram_req;
  assign w_cnt_load_val = w_take_ram ? c_ram_load : c_rom_load;
`else
  localparam int unsigned c_unused_ram_wait = RAM_WAIT;

  logic w_unused_ram_req;

  assign w_unused_ram_req = bus.ram_req;
  assign w_take_ram       = 1'b0;
  assign w_cnt_load_val   = c_rom_load;
`endif
  assign w_take_rom = w_idle && !bus.jump_req && !w_take_ram && bus.fetch_req;

  // The counter is loaded with WAIT-1 as the read state is entered, so it
  // reaches zero exactly on the last strobe cycle.
  assign w_cnt_load = w_take_ram || w_take_rom;
  assign w_cnt_dec  = ((r_state == S_ROM_RD) || (r_state == S_RAM_RD)) && !w_cnt_zero;

  seq_wait_counter u_wait_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // Each branch sets the registered outputs belonging to the state being
  // entered, so the outputs always match the current state (Moore).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc_signals  <= '0;
      r_pc_bus      <= '0;
      r_rom_cs      <= 1'b0;
      r_rom_rd      <= 1'b0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_jump_done   <= 1'b0;
      r_busy        <= 1'b0;
`ifdef MPP_SEQ_RAM_EN
      r_ram_cs      <= 1'b0;
      r_ram_rd      <= 1'b0;
      r_ram_valid   <= 1'b0;
      r_ram_data    <= '0;
`endif
    end else begin
      r_pc_signals  <= '0;
      r_pc_bus      <= '0;
      r_rom_cs      <= 1'b0;
      r_rom_rd      <= 1'b0;
      r_instr_valid <= 1'b0;
      r_jump_done   <= 1'b0;
      r_busy        <= 1'b0;
`ifdef MPP_SEQ_RAM_EN
      r_ram_cs      <= 1'b0;
      r_ram_rd      <= 1'b0;
      r_ram_valid   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_take_jump) begin
            r_state      <= S_LD_LOW;
            r_pc_signals <= PC_CW_LD_LOW;
            r_pc_bus     <= bus.jump_addr[7:0];
            r_busy       <= 1'b1;
          end
`ifdef MPP_SEQ_RAM_EN
          else if (w_take_ram) begin
            r_state  <= S_RAM_RD;
            r_ram_cs <= 1'b1;
            r_ram_rd <= 1'b1;
            r_busy   <= 1'b1;
          end
`endif
          else if (w_take_rom) begin
            r_state      <= S_ROM_RD;
            r_rom_cs     <= 1'b1;
            r_rom_rd     <= 1'b1;
            r_pc_signals <= PC_CW_ROM_RD;
            r_busy       <= 1'b1;
          end
        end
        S_ROM_RD: begin
          r_busy <= 1'b1;
          if (w_cnt_zero) begin
            r_state       <= S_ROM_DONE;
            r_instr       <= bus.data_in;
            r_instr_valid <= 1'b1;
            r_pc_signals  <= PC_CW_INC;
          end else begin
            r_rom_cs     <= 1'b1;
            r_rom_rd     <= 1'b1;
            r_pc_signals <= PC_CW_ROM_RD;
          end
        end
        S_LD_LOW: begin
          r_state      <= S_LD_HIGH;
          r_pc_signals <= PC_CW_LD_HIGH;
          r_pc_bus     <= bus.jump_addr[15:8];
          r_jump_done  <= 1'b1;
          r_busy       <= 1'b1;
        end
`ifdef MPP_SEQ_RAM_EN
        S_RAM_RD: begin
          r_busy <= 1'b1;
          if (w_cnt_zero) begin
            r_state     <= S_RAM_DONE;
            r_ram_data  <= bus.data_in;
            r_ram_valid <= 1'b1;
          end else begin
            r_ram_cs <= 1'b1;
            r_ram_rd <= 1'b1;
          end
        end
`endif
        // ROM_DONE, LD_HIGH, RAM_DONE and any unreachable code return to idle.
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pc_signals  = r_pc_signals;
  assign bus.pc_bus      = r_pc_bus;
  assign bus.rom_cs      = r_rom_cs;
  assign bus.rom_rd      = r_rom_rd;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.jump_done   = r_jump_done;
  assign bus.busy        = r_busy;
`ifdef MPP_SEQ_RAM_EN
  assign bus.ram_cs      = r_ram_cs;
  assign bus.ram_rd      = r_ram_rd;
  assign bus.ram_valid   = r_ram_valid;
  assign bus.ram_data    = r_ram_data;
`else
  assign bus.ram_cs      = 1'b0;
  assign bus.ram_rd      = 1'b0;
  assign bus.ram_valid   = 1'b0;
  assign bus.ram_data    = '0;
`endif

endmodule : mem_sequencer
`default_nettype wire

// File: tb/tb_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_sequencer
// Purpose : Self-checking bench for mem_sequencer. A timeline model built
//           from the request priorities and per-operation durations
//           predicts every output on every cycle of each scenario.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_sequencer;

  localparam int ROM_W = 3;
  localparam int RAM_W = 2;
  localparam int MAXC  = 64;
`ifdef MPP_SEQ_RAM_EN
  localparam bit RAM_ON = 1'b1;
`else
  localparam bit RAM_ON = 1'b0;
`endif

  typedef struct packed {
    logic       rom_cs;
    logic       rom_rd;
    logic       ram_cs;
    logic       ram_rd;
    logic [4:0] pcs;
    logic [7:0] pcb;
    logic       iv;
    logic       jd;
    logic       rv;
    logic       busy;
    logic [7:0] instr;
    logic [7:0] ram_data;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  mem_sequencer_if bus ();

  mem_sequencer #(
    .ROM_WAIT (ROM_W),
    .RAM_WAIT (RAM_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  obs_t        exp_tr [MAXC];
  logic [7:0]  din    [MAXC];
  logic [7:0]  cap_i  [MAXC];
  logic [7:0]  cap_r  [MAXC];
  int          n_end;
  int          drop_j, drop_r, drop_f;
  bit          req_j, req_r, req_f;
  logic [15:0] m_jaddr;
  logic [7:0]  m_instr = 8'h00;
  logic [7:0]  m_ram   = 8'h00;

  function automatic obs_t observe();
    obs_t o;
    o.rom_cs   = bus.rom_cs;
    o.rom_rd   = bus.rom_rd;
    o.ram_cs   = bus.ram_cs;
    o.ram_rd   = bus.ram_rd;
    o.pcs      = bus.pc_signals;
    o.pcb      = bus.pc_bus;
    o.iv       = bus.instr_valid;
    o.jd       = bus.jump_done;
    o.rv       = bus.ram_valid;
    o.busy     = bus.busy;
    o.instr    = bus.instr;
    o.ram_data = bus.ram_data;
    return o;
  endfunction

  task automatic gen_din();
    for (int k = 0; k < MAXC; k++) din[k] = 8'($urandom);
  endtask

  // Timeline model. Requests are raised before edge 0; cycle k is the
  // interval after edge k-1. Operations run in priority order, each followed
  // by one idle cycle: jump = 2 cycles, RAM = RAM_W+1, fetch = ROM_W+1.
  task automatic plan(input bit jr, input bit rr, input int nf,
                      input bit early_in, input logic [15:0] ja);
    int s;
    bit early;
    logic [7:0] cur_i, cur_r;
    early   = early_in && (nf <= 1);
    req_j   = jr;
    req_r   = rr;
    req_f   = (nf > 0);
    m_jaddr = ja;
    drop_j  = -1;
    drop_r  = -1;
    drop_f  = -1;
    for (int k = 0; k < MAXC; k++) begin
      exp_tr[k] = '0;
      cap_i[k]  = '0;
      cap_r[k]  = '0;
    end
    s = 0;
    if (jr) begin
      exp_tr[s+1].pcs  = 5'b00101;
      exp_tr[s+1].pcb  = ja[7:0];
      exp_tr[s+1].busy = 1'b1;
      exp_tr[s+2].pcs  = 5'b00011;
      exp_tr[s+2].pcb  = ja[15:8];
      exp_tr[s+2].jd   = 1'b1;
      exp_tr[s+2].busy = 1'b1;
      drop_j = early ? s + 1 : s + 2;
      s += 3;
    end
    if (rr && RAM_ON) begin
      for (int k = 1; k <= RAM_W; k++) begin
        exp_tr[s+k].ram_cs = 1'b1;
        exp_tr[s+k].ram_rd = 1'b1;
        exp_tr[s+k].busy   = 1'b1;
      end
      exp_tr[s+RAM_W+1].rv   = 1'b1;
      exp_tr[s+RAM_W+1].busy = 1'b1;
      cap_r[s+RAM_W+1]       = din[s+RAM_W];
      drop_r = early ? s + 1 : s + RAM_W + 1;
      s += RAM_W + 2;
    end
    for (int f = 0; f < nf; f++) begin
      for (int k = 1; k <= ROM_W; k++) begin
        exp_tr[s+k].rom_cs = 1'b1;
        exp_tr[s+k].rom_rd = 1'b1;
        exp_tr[s+k].pcs    = 5'b11000;
        exp_tr[s+k].busy   = 1'b1;
      end
      exp_tr[s+ROM_W+1].iv   = 1'b1;
      exp_tr[s+ROM_W+1].pcs  = 5'b00110;
      exp_tr[s+ROM_W+1].busy = 1'b1;
      cap_i[s+ROM_W+1]       = din[s+ROM_W];
      drop_f = early ? s + 1 : s + ROM_W + 1;
      s += ROM_W + 2;
    end
    n_end = s + 1;
    if (rr && !RAM_ON) drop_r = n_end;
    cur_i = m_instr;
    cur_r = m_ram;
    for (int k = 1; k <= n_end; k++) begin
      if (exp_tr[k].iv) cur_i = cap_i[k];
      if (exp_tr[k].rv) cur_r = cap_r[k];
      exp_tr[k].instr    = cur_i;
      exp_tr[k].ram_data = cur_r;
    end
    m_instr = cur_i;
    m_ram   = cur_r;
  endtask

  task automatic apply_requests();
    bus.jump_addr = m_jaddr;
    bus.jump_req  = req_j;
    bus.ram_req   = req_r;
    bus.fetch_req = req_f;
    bus.data_in   = din[0];
  endtask

  task automatic advance(input int k);
    if (k == drop_j) bus.jump_req  = 1'b0;
    if (k == drop_r) bus.ram_req   = 1'b0;
    if (k == drop_f) bus.fetch_req = 1'b0;
    if (k >= n_end) begin
      bus.jump_req  = 1'b0;
      bus.ram_req   = 1'b0;
      bus.fetch_req = 1'b0;
    end
    bus.data_in = din[k];
  endtask

  task automatic test_reset();
    obs_t o;
    bus.fetch_req = 1'b0;
    bus.jump_req  = 1'b0;
    bus.ram_req   = 1'b0;
    bus.jump_addr = 16'h0000;
    bus.data_in   = 8'h00;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    o = observe();
    n_total++;
    if (o !== '0) $display("FAIL reset_state: got %h expected 0", o);
    else n_pass++;
    rst_n   = 1'b1;
    m_instr = 8'h00;
    m_ram   = 8'h00;
    @(negedge clk);
    o = observe();
    n_total++;
    if (o !== '0) $display("FAIL reset_release_idle: got %h expected 0", o);
    else n_pass++;
  endtask

  task automatic test_fetch();
    obs_t o;
    gen_din();
    din[ROM_W] = 8'hA5;
    plan(1'b0, 1'b0, 1, 1'b0, 16'h0000);
    apply_requests();
    for (int k = 1; k <= n_end; k++) begin
      @(negedge clk);
      o = observe();
      n_total++;
      if (o !== exp_tr[k]) $display("FAIL fetch cycle %0d: got %h expected %h", k, o, exp_tr[k]);
      else n_pass++;
      advance(k);
    end
  endtask

  task automatic test_reset_mid_fetch();
    obs_t o;
    bus.fetch_req = 1'b1;
    bus.data_in   = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if ({bus.rom_cs, bus.rom_rd, bus.busy, bus.instr} !== {3'b111, m_instr})
      $display("FAIL reset_mid_pre: got %b%b%b %h expected 111 %h",
               bus.rom_cs, bus.rom_rd, bus.busy, bus.instr, m_instr);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    o = observe();
    n_total++;
    if (o !== '0) $display("FAIL reset_mid_async: got %h expected 0", o);
    else n_pass++;
    bus.fetch_req = 1'b0;
    m_instr = 8'h00;
    m_ram   = 8'h00;
    repeat (3) begin
      @(negedge clk);
      o = observe();
      n_total++;
      if (o !== '0) $display("FAIL reset_mid_hold: got %h expected 0", o);
      else n_pass++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      o = observe();
      n_total++;
      if (o !== '0) $display("FAIL reset_mid_after: got %h expected 0", o);
      else n_pass++;
    end
  endtask

  task automatic test_jump();
    obs_t o;
    gen_din();
    plan(1'b1, 1'b0, 0, 1'b0, 16'h1234);
    apply_requests();
    for (int k = 1; k <= n_end; k++) begin
      @(negedge clk);
      o = observe();
      n_total++;
      if (o !== exp_tr[k]) $display("FAIL jump cycle %0d: got %h expected %h", k, o, exp_tr[k]);
      else n_pass++;
      advance(k);
    end
  endtask

`ifdef MPP_SEQ_RAM_EN
  task automatic test_ram();
    obs_t o;
    gen_din();
    din[RAM_W] = 8'h5A;
    plan(1'b0, 1'b1, 0, 1'b0, 16'h0000);
    apply_requests();
    for (int k = 1; k <= n_end; k++) begin
      @(negedge clk);
      o = observe();
      n_total++;
      if (o !== exp_tr[k]) $display("FAIL ram cycle %0d: got %h expected %h", k, o, exp_tr[k]);
      else n_pass++;
      advance(k);
    end
  endtask
`else
  task automatic test_ram_disabled();
    bus.ram_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_total++;
      if ({bus.busy, bus.ram_cs, bus.ram_rd, bus.ram_valid, bus.ram_data} !== 12'h000)
        $display("FAIL ram_disabled cycle %0d: got busy=%b cs=%b rd=%b valid=%b data=%h expected all 0",
                 k, bus.busy, bus.ram_cs, bus.ram_rd, bus.ram_valid, bus.ram_data);
      else n_pass++;
    end
    bus.ram_req = 1'b0;
  endtask
`endif

  task automatic test_priority();
    obs_t o;
    gen_din();
    plan(1'b1, 1'b1, 1, 1'b0, 16'hBEEF);
    apply_requests();
    for (int k = 1; k <= n_end; k++) begin
      @(negedge clk);
      o = observe();
      n_total++;
      if (o !== exp_tr[k]) $display("FAIL priority cycle %0d: got %h expected %h", k, o, exp_tr[k]);
      else n_pass++;
      advance(k);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    gen_din();
    plan(1'b0, 1'b0, 3, 1'b0, 16'h0000);
    apply_requests();
    for (int k = 1; k <= n_end; k++) begin
      @(negedge clk);
      o = observe();
      n_total++;
      if (o !== exp_tr[k]) $display("FAIL back_to_back cycle %0d: got %h expected %h", k, o, exp_tr[k]);
      else n_pass++;
      advance(k);
    end
  endtask

  task automatic test_random();
    obs_t o;
    bit jr, rr, early;
    int nf;
    for (int it = 0; it < 12; it++) begin
      jr    = 1'($urandom_range(0, 1));
      rr    = 1'($urandom_range(0, 1));
      nf    = $urandom_range(0, 3);
      early = 1'($urandom_range(0, 1));
      if (!jr && !rr && nf == 0) nf = 1;
      gen_din();
      plan(jr, rr, nf, early, 16'($urandom));
      apply_requests();
      for (int k = 1; k <= n_end; k++) begin
        @(negedge clk);
        o = observe();
        n_total++;
        if (o !== exp_tr[k])
          $display("FAIL random it %0d (j=%0b r=%0b f=%0d e=%0b) cycle %0d: got %h expected %h",
                   it, jr, rr, nf, early, k, o, exp_tr[k]);
        else n_pass++;
        advance(k);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch();
    test_reset_mid_fetch();
    test_jump();
`ifdef MPP_SEQ_RAM_EN
    test_ram();
`else
    test_ram_disabled();
`endif
    test_priority();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mem_sequencer
`default_nettype wire
